aes_loopback_tester: RTL and testbench

Parametrised built-in self-test controller for the AES encrypt/decrypt pair. It drives NUM_VECTORS generated plaintexts through the encryption path, then feeds each ciphertext through the decryption path and compares the result with the original plaintext. It optionally checks vector 0 against a known-answer ciphertext, counts passes and failures, records the first failing index, and flags hung cores by timeout. It sits at top level in place of the fixed single-vector 256-bit wrapper and supports NK = 4/6/8, so one block serves AES-128/192/256.

---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_vec_gen.sv | 28 ++
 rtl/aes_loopback_tester.sv | 211 +++++++++++++++++++++
 tb/tb_aes_loopback_tester.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES loopback self-test controller.
package aes_pkg;

  localparam int NB      = 4;
  localparam int BLOCK_W = 128;

  localparam logic [15:0] IDX_NONE = 16'hFFFF;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENC_REQ,
    ST_ENC_WAIT,
    ST_DEC_REQ,
    ST_DEC_WAIT,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } tester_state_e;

  // Number of AES rounds for a key of nk 32-bit words.
  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  // Only AES-128/192/256 key lengths are supported.
  function automatic bit nk_legal(input int nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

endpackage

// File: rtl/aes_vec_gen.sv
// Vector index register and plaintext generation: msg = BASE_MSG ^ {4{idx}}.
module aes_vec_gen
  import aes_pkg::*;
#(
  parameter logic [BLOCK_W-1:0] BASE_MSG = 128'h00112233445566778899aabbccddeeff
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [15:0]        idx,
  output logic [BLOCK_W-1:0] msg
);

  // Index restarts at 0 on reset or run start and advances once per checked vector.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= 16'd0;
    end else if (inc) begin
      idx <= idx + 16'd1;
    end
  end

  // The plaintext is a pure function of the index register, so it stays stable
  // for the whole encrypt/decrypt round trip of a vector.
  assign msg = BASE_MSG ^ {NB{{16'd0, idx}}};

endmodule

// File: rtl/aes_loopback_tester.sv
// Built-in self-test controller: encrypts generated plaintexts, decrypts the
// ciphertexts, compares against the originals and keeps a pass/fail scoreboard.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | waiting for start after reset
// ST_ENC_REQ   | enc_start pulse for the current vector
// ST_ENC_WAIT  | waiting for enc_done, timeout counter running
// ST_DEC_REQ   | dec_start pulse with the captured ciphertext
// ST_DEC_WAIT  | waiting for dec_done, timeout counter running
// ST_CHECK     | compare recovered plaintext (and KAT on vector 0), score it
// ST_DONE      | results held; start or continuous launches a new run
// ST_ERROR     | a core hung; only rst leaves this state
module aes_loopback_tester
  import aes_pkg::*;
#(
  parameter int                 NK             = 8,
  parameter int                 NUM_VECTORS    = 16,
  parameter int                 TIMEOUT_CYCLES = 4096,
  parameter logic [255:0]       KEY            = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
  parameter logic [BLOCK_W-1:0] BASE_MSG       = 128'h00112233445566778899aabbccddeeff,
  parameter bit                 KAT_EN         = 1'b1,
  parameter logic [BLOCK_W-1:0] KAT_CT         = 128'h8ea2b7ca516745bfeafc49904b496089
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                continuous,
  output logic [32*NK-1:0]    enc_key,
  output logic [BLOCK_W-1:0]  enc_msg,
  output logic                enc_start,
  input  logic                enc_done,
  input  logic [BLOCK_W-1:0]  enc_ct,
  output logic [32*NK-1:0]    dec_key,
  output logic [BLOCK_W-1:0]  dec_msg,
  output logic                dec_start,
  input  logic                dec_done,
  input  logic [BLOCK_W-1:0]  dec_pt,
  output logic                busy,
  output logic                done,
  output logic                pass_led,
  output logic                timeout,
  output logic [15:0]         pass_count,
  output logic [15:0]         fail_count,
  output logic [15:0]         first_fail_idx
);

  if (!nk_legal(NK)) begin : g_bad_nk
    $error("aes_loopback_tester: NK must be 4, 6 or 8");
  end
  if ((NUM_VECTORS < 1) || (NUM_VECTORS > 65535)) begin : g_bad_nv
    $error("aes_loopback_tester: NUM_VECTORS must be in 1..65535");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("aes_loopback_tester: TIMEOUT_CYCLES must be at least 1");
  end

  localparam int           TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]  LAST_IDX = 16'(NUM_VECTORS - 1);

  tester_state_e        state;
  logic [TW-1:0]        wait_cnt;
  logic [BLOCK_W-1:0]   ct_q;
  logic [BLOCK_W-1:0]   pt_q;
  logic                 enc_start_q;
  logic                 dec_start_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 timeout_q;
  logic [15:0]          pass_cnt;
  logic [15:0]          fail_cnt;
  logic [15:0]          first_fail;

  logic [15:0]          vec_idx;
  logic                 vec_clr;
  logic                 vec_inc;
  logic                 run_req;
  logic                 last_vec;
  logic                 kat_bad;
  logic                 vec_ok;

  aes_vec_gen #(
    .BASE_MSG (BASE_MSG)
  ) u_vec_gen (
    .clk (clk),
    .rst (rst),
    .clr (vec_clr),
    .inc (vec_inc),
    .idx (vec_idx),
    .msg (enc_msg)
  );

  // Run launch, index stepping and the per-vector verdict.
  always_comb begin
    run_req  = ((state == ST_IDLE) && start) ||
               ((state == ST_DONE) && (start || continuous));
    last_vec = (vec_idx == LAST_IDX);
    vec_clr  = run_req;
    vec_inc  = (state == ST_CHECK) && !last_vec;
    kat_bad  = KAT_EN && (vec_idx == 16'd0) && (ct_q != KAT_CT);
    vec_ok   = (pt_q == enc_msg) && !kat_bad;
  end

  // Sequencer, timeout counter and scoreboard; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      ct_q        <= '0;
      pt_q        <= '0;
      enc_start_q <= 1'b0;
      dec_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      pass_cnt    <= 16'd0;
      fail_cnt    <= 16'd0;
      first_fail  <= IDX_NONE;
    end else begin
      enc_start_q <= 1'b0;
      dec_start_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (run_req) begin
            state       <= ST_ENC_REQ;
            enc_start_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            pass_cnt    <= 16'd0;
            fail_cnt    <= 16'd0;
            first_fail  <= IDX_NONE;
          end
        end
        ST_ENC_REQ: begin
          state    <= ST_ENC_WAIT;
          wait_cnt <= '0;
        end
        ST_ENC_WAIT: begin
          // A done pulse on the last count takes priority over the timeout.
          if (enc_done) begin
            ct_q        <= enc_ct;
            state       <= ST_DEC_REQ;
            dec_start_q <= 1'b1;
          end else if (wait_cnt == TO_LAST) begin
            state     <= ST_ERROR;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DEC_REQ: begin
          state    <= ST_DEC_WAIT;
          wait_cnt <= '0;
        end
        ST_DEC_WAIT: begin
          if (dec_done) begin
            pt_q  <= dec_pt;
            state <= ST_CHECK;
          end else if (wait_cnt == TO_LAST) begin
            state     <= ST_ERROR;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (vec_ok) begin
            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 16'd1;
          end else begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 16'd1;
            if (first_fail == IDX_NONE) first_fail <= vec_idx;
          end
          if (last_vec) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state       <= ST_ENC_REQ;
            enc_start_q <= 1'b1;
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign enc_key        = KEY[32*NK-1:0];
  assign dec_key        = KEY[32*NK-1:0];
  assign dec_msg        = ct_q;
  assign enc_start      = enc_start_q;
  assign dec_start      = dec_start_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign pass_count     = pass_cnt;
  assign fail_count     = fail_cnt;
  assign first_fail_idx = first_fail;
  assign pass_led       = done_q & (fail_cnt == 16'd0) & ~timeout_q;

endmodule

// File: tb/tb_aes_loopback_tester.sv
// Scoreboard bench for aes_loopback_tester using a reversible toy cipher as the
// encrypt/decrypt cores, with randomized latencies, corruption and stray pulses.
module tb_aes_loopback_tester;

  localparam int NK = 4;
  localparam int NV = 8;
  localparam int TO = 64;
  localparam int KW = 32 * NK;
  localparam logic [255:0] KEY      = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] BASE     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] MASK_STD = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] MASK_ALT = 128'h3141592653589793238462643383279f;
  localparam logic [KW-1:0] KEY_USED = KEY[KW-1:0];

  // Toy cipher: rotate left by one byte, then xor key and mask.
  function automatic logic [127:0] toy_enc(input logic [127:0] pt, input logic [127:0] k,
                                           input logic [127:0] m);
    return {pt[119:0], pt[127:120]} ^ k ^ m;
  endfunction

  function automatic logic [127:0] toy_dec(input logic [127:0] ct, input logic [127:0] k,
                                           input logic [127:0] m);
    logic [127:0] x;
    x = ct ^ k ^ m;
    return {x[7:0], x[127:8]};
  endfunction

  localparam logic [127:0] KAT = toy_enc(BASE, KEY_USED, MASK_STD);

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] fc;
    logic [15:0] ff;
    logic        to;
    logic        led;
  } res_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          continuous;
  logic [KW-1:0] enc_key;
  logic [127:0]  enc_msg;
  logic          enc_start;
  logic          enc_done;
  logic [127:0]  enc_ct;
  logic [KW-1:0] dec_key;
  logic [127:0]  dec_msg;
  logic          dec_start;
  logic          dec_done;
  logic [127:0]  dec_pt;
  logic          busy;
  logic          done;
  logic          pass_led;
  logic          timeout;
  logic [15:0]   pass_count;
  logic [15:0]   fail_count;
  logic [15:0]   first_fail_idx;

  int n_checks = 0;
  int n_err    = 0;

  logic [127:0] exp_pt[$];
  logic [127:0] exp_ct[$];
  res_t         exp_res[$];

  int           enc_lat_fix = -1;
  int           dec_lat_fix = -1;
  bit           enc_mute    = 1'b0;
  bit           use_alt     = 1'b0;
  logic [NV-1:0] corrupt    = '0;
  int           dec_seen    = 0;

  aes_loopback_tester #(
    .NK             (NK),
    .NUM_VECTORS    (NV),
    .TIMEOUT_CYCLES (TO),
    .KEY            (KEY),
    .BASE_MSG       (BASE),
    .KAT_EN         (1'b1),
    .KAT_CT         (KAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .continuous     (continuous),
    .enc_key        (enc_key),
    .enc_msg        (enc_msg),
    .enc_start      (enc_start),
    .enc_done       (enc_done),
    .enc_ct         (enc_ct),
    .dec_key        (dec_key),
    .dec_msg        (dec_msg),
    .dec_start      (dec_start),
    .dec_done       (dec_done),
    .dec_pt         (dec_pt),
    .busy           (busy),
    .done           (done),
    .pass_led       (pass_led),
    .timeout        (timeout),
    .pass_count     (pass_count),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outcome of one full run from the pass/fail rules.
  function automatic res_t model_run(input logic [NV-1:0] corr, input bit alt);
    res_t r;
    r.pc = 16'd0;
    r.fc = 16'd0;
    r.ff = 16'hFFFF;
    r.to = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (corr[i] || (i == 0 && alt)) begin
        r.fc++;
        if (r.ff == 16'hFFFF) r.ff = 16'(i);
      end else begin
        r.pc++;
      end
    end
    r.led = (r.fc == 16'd0);
    return r;
  endfunction

  task automatic push_pts();
    logic [31:0] iv;
    for (int i = 0; i < NV; i++) begin
      iv = 32'(i);
      exp_pt.push_back(BASE ^ {4{iv}});
    end
  endtask

  task automatic flush();
    exp_pt.delete();
    exp_ct.delete();
    exp_res.delete();
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_enc_start"}, enc_start, 1'b0);
    chk({p, "_dec_start"}, dec_start, 1'b0);
    chk({p, "_busy"}, busy, 1'b0);
    chk({p, "_done"}, done, 1'b0);
    chk({p, "_pass_led"}, pass_led, 1'b0);
    chk({p, "_timeout"}, timeout, 1'b0);
    chk({p, "_pass_count"}, pass_count, 16'd0);
    chk({p, "_fail_count"}, fail_count, 16'd0);
    chk({p, "_first_fail"}, first_fail_idx, 16'hFFFF);
    chk({p, "_enc_msg"}, enc_msg, BASE);
    chk({p, "_dec_msg"}, dec_msg, 128'd0);
  endtask

  // Pulse start, then count falling edges until done (k = edges after the start edge).
  task automatic run_and_wait(input int budget, input bit poke, output int k);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
      start = poke && (k == 20);
    end
    start = 1'b0;
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL run_wait: done not seen within %0d cycles", budget);
    end
  endtask

  task automatic do_run(input logic [NV-1:0] corr, input bit alt, input bit poke, output int k);
    corrupt = corr;
    use_alt = alt;
    flush();
    push_pts();
    exp_res.push_back(model_run(corr, alt));
    run_and_wait(3000, poke, k);
    repeat (3) @(negedge clk);
  endtask

  // Encryption core model; also emits a stray enc_done outside the wait state.
  initial begin : enc_core
    logic [127:0] ct;
    int           l;
    enc_done = 1'b0;
    enc_ct   = '0;
    forever begin
      @(negedge clk);
      if (enc_start && !rst && !enc_mute) begin
        l  = (enc_lat_fix >= 0) ? enc_lat_fix : int'($urandom_range(0, 12));
        ct = toy_enc(enc_msg, enc_key, use_alt ? MASK_ALT : MASK_STD);
        exp_ct.push_back(ct);
        repeat (l + 1) @(negedge clk);
        enc_done = 1'b1;
        enc_ct   = ct;
        @(negedge clk);
        enc_done = 1'b0;
        enc_ct   = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 1) == 1) begin
          @(negedge clk);
          enc_done = 1'b1;
          @(negedge clk);
          enc_done = 1'b0;
        end
      end
    end
  end

  // Decryption core model; flips one bit for vectors selected in 'corrupt'.
  initial begin : dec_core
    logic [127:0] pt;
    logic [127:0] one;
    logic [31:0]  iv;
    int           l;
    dec_done = 1'b0;
    dec_pt   = '0;
    one      = 128'h1;
    forever begin
      @(negedge clk);
      if (dec_start && !rst) begin
        l  = (dec_lat_fix >= 0) ? dec_lat_fix : int'($urandom_range(0, 12));
        pt = toy_dec(dec_msg, dec_key, use_alt ? MASK_ALT : MASK_STD);
        iv = pt[31:0] ^ BASE[31:0];
        if (iv < NV && corrupt[iv[2:0]]) pt = pt ^ (one << $urandom_range(0, 127));
        repeat (l + 1) @(negedge clk);
        dec_done = 1'b1;
        dec_pt   = pt;
        @(negedge clk);
        dec_done = 1'b0;
        dec_pt   = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 1) == 1) begin
          @(negedge clk);
          dec_done = 1'b1;
          @(negedge clk);
          dec_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request or completes a run.
  initial begin : monitor
    logic [127:0] e;
    res_t         r;
    logic         done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (enc_start) begin
          chk("enc_key", enc_key, KEY_USED);
          if (exp_pt.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL enc_start_unexpected: enc_msg %0h with no vector pending", enc_msg);
          end else begin
            e = exp_pt.pop_front();
            chk("enc_msg", enc_msg, e);
          end
        end
        if (dec_start) begin
          dec_seen++;
          chk("dec_key", dec_key, KEY_USED);
          if (exp_ct.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL dec_start_unexpected: dec_msg %0h with no ciphertext pending", dec_msg);
          end else begin
            e = exp_ct.pop_front();
            chk("dec_msg", dec_msg, e);
          end
        end
        if (done && !done_prev) begin
          if (exp_res.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL done_unexpected: done rose with no run pending");
          end else begin
            r = exp_res.pop_front();
            chk("pass_count", pass_count, r.pc);
            chk("fail_count", fail_count, r.fc);
            chk("first_fail_idx", first_fail_idx, r.ff);
            chk("timeout", timeout, r.to);
            chk("pass_led", pass_led, r.led);
            chk("busy_at_done", busy, 1'b0);
          end
        end
        done_prev = done;
      end else begin
        done_prev = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    logic [NV-1:0] c;
    rst        = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst_hold");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("idle");

    // Fixed latency 3: every vector costs 5 + 2*3 cycles.
    enc_lat_fix = 3;
    dec_lat_fix = 3;
    do_run('0, 1'b0, 1'b0, k);
    chk("done_cycle", 32'(k), 32'(NV * (5 + 2 * 3)));
    enc_lat_fix = -1;
    dec_lat_fix = -1;

    // Single corrupted vector at a random index.
    c = '0;
    c[$urandom_range(1, NV - 1)] = 1'b1;
    do_run(c, 1'b0, 1'b1, k);

    // Wrong known-answer (consistent cores, different mask): vector 0 fails only.
    do_run('0, 1'b1, 1'b0, k);

    // Random corruption patterns.
    for (int r = 0; r < 6; r++) begin
      c = NV'($urandom & $urandom);
      do_run(c, ($urandom_range(0, 3) == 0), r[0], k);
    end

    // Done on the last timeout count must win.
    enc_lat_fix = TO - 1;
    do_run('0, 1'b0, 1'b0, k);
    chk("last_count_timeout", timeout, 1'b0);
    enc_lat_fix = -1;

    // Hung encryption core.
    enc_mute = 1'b1;
    flush();
    exp_pt.push_back(BASE);
    exp_res.push_back('{pc: 16'd0, fc: 16'd0, ff: 16'hFFFF, to: 1'b1, led: 1'b0});
    run_and_wait(500, 1'b0, k);
    chk("timeout_cycle", 32'(k), 32'(TO + 1));
    chk("err_timeout", timeout, 1'b1);
    chk("err_done", done, 1'b1);
    chk("err_busy", busy, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_sticky_timeout", timeout, 1'b1);
    chk("err_sticky_busy", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("after_err_rst");
    enc_mute = 1'b0;

    // Reset during DEC_WAIT of vector 3 with a late dec_done afterwards.
    dec_lat_fix = 30;
    corrupt = '0;
    use_alt = 1'b0;
    flush();
    push_pts();
    dec_seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (dec_seen < 4 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (dec_seen < 4) begin
      n_checks++;
      n_err++;
      $display("FAIL abort_wait: vector 3 decrypt not reached, dec_seen %0d", dec_seen);
    end
    repeat (5) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("abort");
    repeat (40) @(negedge clk);
    chk_reset("abort_late");
    dec_lat_fix = -1;
    flush();

    // continuous=1 restarts from DONE with cleared counters.
    c = '0;
    c[$urandom_range(0, NV - 1)] = 1'b1;
    corrupt = c;
    use_alt = 1'b0;
    push_pts();
    push_pts();
    exp_res.push_back(model_run(c, 1'b0));
    exp_res.push_back(model_run(c, 1'b0));
    continuous = 1'b1;
    run_and_wait(3000, 1'b0, k);
    @(negedge clk);
    continuous = 1'b0;
    chk("cont_busy", busy, 1'b1);
    chk("cont_enc_start", enc_start, 1'b1);
    chk("cont_pass_cleared", pass_count, 16'd0);
    chk("cont_fail_cleared", fail_count, 16'd0);
    chk("cont_ff_cleared", first_fail_idx, 16'hFFFF);
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL cont_wait: second run did not finish within 3000 cycles");
    end
    repeat (10) @(negedge clk);
    chk("cont_hold_done", done, 1'b1);
    chk("cont_hold_busy", busy, 1'b0);
    chk("queues_drained", 32'(exp_pt.size() + exp_ct.size() + exp_res.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
